// File: rtl/dma_copy_engine.sv
// Word-by-word memory-to-memory copy engine: one read cycle then one write cycle per word.
// Optional IO-region guard is enabled by defining DMA_IO_GUARD_EN.
module dma_copy_engine #(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32,
    parameter int LEN_BIT_WIDTH  = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_BIT_WIDTH-1:0] src_addr,
    input  logic [ADDR_BIT_WIDTH-1:0] dst_addr,
    input  logic [LEN_BIT_WIDTH-1:0]  len_words,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [ADDR_BIT_WIDTH-1:0] mem_addr,
    output logic                      mem_wrtEn,
    output logic [DATA_BIT_WIDTH-1:0] mem_wdata,
    input  logic [DATA_BIT_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t                    state;
    state_t                    next_state;
    logic [ADDR_BIT_WIDTH-1:0] src_ptr;
    logic [ADDR_BIT_WIDTH-1:0] dst_ptr;
    logic [ADDR_BIT_WIDTH-1:0] last_addr;
    logic [LEN_BIT_WIDTH-1:0]  count;
    logic [DATA_BIT_WIDTH-1:0] word_buf;
    logic                      guard_hit;
    logic                      launch;

`ifdef DMA_IO_GUARD_EN
    logic err_flag;
    assign guard_hit = src_addr[29] | dst_addr[29];
    assign err       = err_flag;

    // Sticky until the next start taken in IDLE, which reloads it with its own guard result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag <= 1'b0;
        end else if (state == IDLE && start) begin
            err_flag <= guard_hit;
        end
    end
`else
    assign guard_hit = 1'b0;
    assign err       = 1'b0;
`endif

    assign launch = start && !guard_hit && (len_words != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            last_addr <= '0;
            count     <= '0;
            word_buf  <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (launch) begin
                        src_ptr <= src_addr;
                        dst_ptr <= dst_addr;
                        count   <= len_words;
                    end
                end
                READ: begin
                    word_buf  <= mem_rdata;
                    last_addr <= src_ptr;
                end
                WRITE: begin
                    // Pointers wrap naturally at the address width.
                    src_ptr   <= src_ptr + ADDR_BIT_WIDTH'(4);
                    dst_ptr   <= dst_ptr + ADDR_BIT_WIDTH'(4);
                    count     <= count - LEN_BIT_WIDTH'(1);
                    last_addr <= dst_ptr;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        done       = 1'b0;
        mem_wrtEn  = 1'b0;
        mem_addr   = last_addr;
        mem_wdata  = word_buf;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = launch ? READ : FINISH;
                end
            end
            READ: begin
                mem_addr   = src_ptr;
                next_state = WRITE;
            end
            WRITE: begin
                mem_addr   = dst_ptr;
                mem_wrtEn  = 1'b1;
                next_state = (count == LEN_BIT_WIDTH'(1)) ? FINISH : READ;
            end
            FINISH: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Self-checking bench for dma_copy_engine: word-array memory, bus logger and a copy reference model.
// Expectations follow DMA_IO_GUARD_EN when it is defined for the build.
module tb_dma_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [10:0] len_words;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic        mem_wrtEn;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem       [0:1023];
    logic [31:0] model_mem [0:1023];

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] rd_addr_q[$];
    logic [31:0] exp_wa_q[$];
    logic [31:0] exp_wd_q[$];
    logic [31:0] exp_ra_q[$];
    int          exp_lat;
    logic        exp_err;

    dma_copy_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len_words (len_words),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wrtEn (mem_wrtEn),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];

    // Bus logger and memory write port; a read cycle is busy, not writing and not done.
    always @(posedge clk) begin
        if (rst_n && mem_wrtEn) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            mem[mem_addr[11:2]] = mem_wdata;
        end
        if (rst_n && busy && !mem_wrtEn && !done) begin
            rd_addr_q.push_back(mem_addr);
        end
    end

    task automatic sync_model();
        for (int i = 0; i < 1024; i++) model_mem[i] = mem[i];
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
    endtask

    // Reference: ascending word copy, 2 cycles per word plus one FINISH cycle.
    task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] ra;
        logic [31:0] wa;
        logic [31:0] data;
        logic        blocked;
        exp_wa_q.delete();
        exp_wd_q.delete();
        exp_ra_q.delete();
`ifdef DMA_IO_GUARD_EN
        blocked = s[29] | d[29];
`else
        blocked = 1'b0;
`endif
        exp_err = blocked;
        exp_lat = blocked ? 1 : 2 * n + 1;
        if (!blocked) begin
            for (int i = 0; i < n; i++) begin
                ra   = s + 32'(4 * i);
                wa   = d + 32'(4 * i);
                data = model_mem[ra[11:2]];
                exp_ra_q.push_back(ra);
                exp_wa_q.push_back(wa);
                exp_wd_q.push_back(data);
                model_mem[wa[11:2]] = data;
            end
        end
    endtask

    task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [10:0] n);
        @(negedge clk);
        src_addr  = s;
        dst_addr  = d;
        len_words = n;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge of cycle 1 after the start edge; returns done latency or 999 on timeout.
    task automatic wait_done(inout int lat);
        while (!done && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = 999;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len_words = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, mem_wrtEn} !== 4'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%b wrtEn=%b addr=%h wdata=%h, required all 0",
                     busy, done, err, mem_wrtEn, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat = 1;
        mem[12'h100 >> 2] = 32'hA;
        mem[12'h104 >> 2] = 32'hB;
        mem[12'h108 >> 2] = 32'hC;
        sync_model();
        clear_logs();
        model_copy(32'h100, 32'h200, 3);
        start_copy(32'h100, 32'h200, 11'd3);
        wait_done(lat);
        checks++;
        if (lat !== 7) begin
            failures++;
            $display("FAIL basic_latency: got %0d cycles, required 7", lat);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[(12'h200 >> 2) + i] !== 32'hA + 32'(i)) begin
                failures++;
                $display("FAIL basic_word%0d: got %h, required %h", i, mem[(12'h200 >> 2) + i], 32'hA + 32'(i));
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse: done=%b busy=%b after pulse, required 0 0", done, busy);
        end
    endtask

    task automatic test_zero_len();
        int lat = 1;
        clear_logs();
        start_copy(32'h100, 32'h300, 11'd0);
        wait_done(lat);
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL zero_len_latency: got %0d cycles, required 1", lat);
        end
        @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 0 || rd_addr_q.size() != 0) begin
            failures++;
            $display("FAIL zero_len_bus: got %0d writes %0d reads, required 0 0", wr_addr_q.size(), rd_addr_q.size());
        end
    endtask

    task automatic test_random();
        logic [31:0] s;
        logic [31:0] d;
        int          n;
        int          lat;
        int          bad;
        for (int t = 0; t < 10; t++) begin
            s = 32'($urandom_range(0, 1000)) << 2;
            d = 32'($urandom_range(0, 1000)) << 2;
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) mem[(s[11:2] + 10'(i))] = $urandom;
            sync_model();
            clear_logs();
            model_copy(s, d, n);
            lat = 1;
            start_copy(s, d, 11'(n));
            wait_done(lat);
            checks++;
            if (lat !== exp_lat) begin
                failures++;
                $display("FAIL random%0d_latency: got %0d, required %0d", t, lat, exp_lat);
            end
            bad = 0;
            if (wr_addr_q.size() != exp_wa_q.size() || rd_addr_q.size() != exp_ra_q.size()) bad = 1;
            else foreach (exp_wa_q[i])
                if (wr_addr_q[i] !== exp_wa_q[i] || wr_data_q[i] !== exp_wd_q[i] || rd_addr_q[i] !== exp_ra_q[i]) bad = 1;
            for (int i = 0; i < 1024; i++) if (mem[i] !== model_mem[i]) bad = 1;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL random%0d_transfer: src=%h dst=%h n=%0d got %0d writes, required %0d, bus/memory differs from model",
                         t, s, d, n, wr_addr_q.size(), exp_wa_q.size());
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat = 1;
        for (int i = 0; i < 4; i++) mem[(12'h500 >> 2) + i] = $urandom;
        sync_model();
        clear_logs();
        model_copy(32'h500, 32'h600, 4);
        start_copy(32'h500, 32'h600, 11'd4);
        @(negedge clk);
        lat++;
        src_addr  = 32'h700;
        dst_addr  = 32'h780;
        len_words = 11'd2;
        start     = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        wait_done(lat);
        checks++;
        if (lat !== 9) begin
            failures++;
            $display("FAIL busy_ignore_latency: got %0d, required 9", lat);
        end
        checks++;
        if (wr_addr_q != exp_wa_q || wr_data_q != exp_wd_q || rd_addr_q != exp_ra_q) begin
            failures++;
            $display("FAIL busy_ignore_bus: got %0d writes %0d reads, required %0d %0d with model addresses/data",
                     wr_addr_q.size(), rd_addr_q.size(), exp_wa_q.size(), exp_ra_q.size());
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_ignore_relaunch: busy=%b after done, required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int guard = 0;
        for (int i = 0; i < 5; i++) mem[(12'h300 >> 2) + i] = $urandom;
        sync_model();
        clear_logs();
        model_copy(32'h300, 32'h380, 5);
        start_copy(32'h300, 32'h380, 11'd5);
        while (wr_addr_q.size() < 2 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, mem_wrtEn} !== 4'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b err=%b wrtEn=%b addr=%h wdata=%h, required all 0",
                     busy, done, err, mem_wrtEn, mem_addr, mem_wdata);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 2 || wr_addr_q[0] !== exp_wa_q[0] || wr_addr_q[1] !== exp_wa_q[1]
            || wr_data_q[0] !== exp_wd_q[0] || wr_data_q[1] !== exp_wd_q[1]) begin
            failures++;
            $display("FAIL reset_mid_writes: got %0d writes, required exactly the first 2 model writes", wr_addr_q.size());
        end
        sync_model();
        clear_logs();
        mem[12'h400 >> 2] = 32'h1234_5678;
        model_mem[12'h400 >> 2] = 32'h1234_5678;
        model_copy(32'h400, 32'h480, 1);
        rst_n     = 1'b1;
        src_addr  = 32'h400;
        dst_addr  = 32'h480;
        len_words = 11'd1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        wait_done(lat);
        checks++;
        if (lat !== 3 || mem[12'h480 >> 2] !== 32'h1234_5678) begin
            failures++;
            $display("FAIL reset_mid_fresh_copy: latency %0d word %h, required 3 12345678", lat, mem[12'h480 >> 2]);
        end
    endtask

    task automatic test_wrap();
        int lat = 1;
        mem[10'h3FF] = 32'hDEAD_0001;
        mem[10'h000] = 32'hDEAD_0002;
        sync_model();
        clear_logs();
        model_copy(32'hFFFF_FFFC, 32'h800, 2);
        start_copy(32'hFFFF_FFFC, 32'h800, 11'd2);
        wait_done(lat);
        checks++;
        if (lat !== exp_lat || err !== exp_err) begin
            failures++;
            $display("FAIL wrap_done: latency %0d err %b, required %0d %b", lat, err, exp_lat, exp_err);
        end
        checks++;
        if (rd_addr_q != exp_ra_q || wr_data_q != exp_wd_q) begin
            failures++;
            $display("FAIL wrap_reads: got %0d reads (2nd %h), required %0d reads matching model",
                     rd_addr_q.size(), (rd_addr_q.size() > 1) ? rd_addr_q[1] : 32'hx, exp_ra_q.size());
        end
    endtask

    task automatic test_io_region();
        int lat = 1;
        sync_model();
        clear_logs();
        model_copy(32'h40, 32'h2000_0004, 2);
        start_copy(32'h40, 32'h2000_0004, 11'd2);
        wait_done(lat);
        checks++;
        if (lat !== exp_lat || err !== exp_err) begin
            failures++;
            $display("FAIL io_done: latency %0d err %b, required %0d %b", lat, err, exp_lat, exp_err);
        end
        checks++;
        if (wr_addr_q != exp_wa_q || wr_data_q != exp_wd_q) begin
            failures++;
            $display("FAIL io_writes: got %0d writes, required %0d", wr_addr_q.size(), exp_wa_q.size());
        end
        @(negedge clk);
        checks++;
        if (err !== exp_err) begin
            failures++;
            $display("FAIL io_err_sticky: err=%b in idle, required %b", err, exp_err);
        end
        sync_model();
        model_copy(32'h40, 32'h80, 1);
        lat = 1;
        start_copy(32'h40, 32'h80, 11'd1);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL io_err_clear: err=%b after valid start, required 0", err);
        end
        wait_done(lat);
        checks++;
        if (lat !== 3 || mem[12'h80 >> 2] !== model_mem[12'h80 >> 2]) begin
            failures++;
            $display("FAIL io_next_copy: latency %0d word %h, required 3 %h", lat, mem[12'h80 >> 2], model_mem[12'h80 >> 2]);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        test_reset();
        test_basic();
        test_zero_len();
        test_random();
        test_busy_ignore();
        test_reset_mid();
        test_wrap();
        test_io_region();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
